// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer that time-shares one combinational
// ALU between two requesters. Each op goes IDLE -> EXEC -> RESP. Operands are
// registered onto the ALU inputs at accept. The result and zero flag are
// captured at the end of EXEC. They are then held in RESP until the owning
// requester takes them.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_ctrl_0,
  input  logic [3:0]       req_ctrl_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant;
  logic             winner;
  logic             accept;
  logic             resp_hs;
  logic [1:0]       req_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] win_a, win_b;
  logic [3:0]       win_ctrl;

  assign req_valid  = {req_valid_1, req_valid_0};
  assign resp_ready = {resp_ready_1, resp_ready_0};

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    winner = req_valid[1];
    if (&req_valid) winner = ~last_grant;
  end

  // Operand mux for the winning requester
  always_comb begin
    win_a    = winner ? req_a_1    : req_a_0;
    win_b    = winner ? req_b_1    : req_b_0;
    win_ctrl = winner ? req_ctrl_1 : req_ctrl_0;
  end

  // Ready is gated by reset_n so no handshake is seen while reset is asserted
  assign accept      = reset_n && (state_q == IDLE) && (|req_valid);
  assign req_ready_0 = accept & ~winner;
  assign req_ready_1 = accept &  winner;

  // In RESP only the owner's ready completes the handshake; the other one is ignored
  assign resp_hs      = (state_q == RESP) && resp_ready[owner];
  assign resp_valid_0 = (state_q == RESP) && !owner;
  assign resp_valid_1 = (state_q == RESP) &&  owner;
  assign busy         = (state_q != IDLE);

  // Next-state logic: EXEC always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers. ALU inputs change only on accept, and the response
  // registers change only at the end of EXEC. A reset mid-operation discards
  // the in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 4'b0000;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= win_a;
        alu_b      <= win_b;
        alu_ctrl   <= win_ctrl;
        owner      <= winner;
        last_grant <= winner;
      end
      if (state_q == EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter. A scoreboard queue is filled at each
// accept. A negedge monitor pops the queue at each response handshake.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;

  logic             clk, reset_n;
  logic             req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [WIDTH-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [3:0]       req_ctrl_0, req_ctrl_1;
  logic             resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_ctrl;
  logic             alu_zero, busy, owner;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: AND, OR, ADD, SUB; any other code gives result 0 and zero 0
  always_comb begin
    alu_zero = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
    if (alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})
      alu_zero = (alu_result == '0);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input bit id);
    return id ? req_ready_1 : req_ready_0;
  endfunction

  // Drive one request, wait a bounded time for its ready, record the expected response
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic [31:0] er, input logic ez,
                       input bit push, output int waited);
    int cnt;
    if (id) begin
      req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_ctrl_1 = ctrl;
    end else begin
      req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_ctrl_0 = ctrl;
    end
    #1;
    cnt = 0;
    while (!rdy(id) && cnt < 20) begin
      tick;
      cnt++;
    end
    chk1("accept", rdy(id), 1'b1);
    if (push) sb.push_back('{id: id, res: er, z: ez});
    waited = cnt;
    tick;
    if (id) req_valid_1 = 1'b0;
    else    req_valid_0 = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been consumed
  task automatic drain;
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 20) begin
      tick;
      cnt++;
    end
    chk32("drain", sb.size(), 0);
  endtask

  // Response monitor: one handshake per pop; a response with nothing expected is an error
  always @(negedge clk) begin
    if (reset_n) begin
      chk1("resp_onehot", resp_valid_0 & resp_valid_1, 1'b0);
      if ((resp_valid_0 && resp_ready_0) || (resp_valid_1 && resp_ready_1)) begin
        if (sb.size() == 0) begin
          chk1("unexpected_resp", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk1("resp_id", resp_valid_1, e.id);
          chk1("resp_owner", owner, e.id);
          chk32("resp_result", resp_result, e.res);
          chk1("resp_zero", resp_zero, e.z);
        end
      end
    end
  end

  initial begin
    int w;
    reset_n = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    req_ctrl_0 = '0; req_ctrl_1 = '0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state, with ready gated during reset
    tick;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk32("rst_alu_a", alu_a, 0);
    chk32("rst_alu_b", alu_b, 0);
    chk32("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk32("rst_result", resp_result, 0);
    chk1("rst_zero", resp_zero, 1'b0);
    chk1("rst_rv0", resp_valid_0, 1'b0);
    chk1("rst_rv1", resp_valid_1, 1'b0);
    req_valid_0 = 1'b1;
    #1;
    chk1("rst_ready_gated", req_ready_0, 1'b0);
    req_valid_0 = 1'b0;
    reset_n = 1'b1;
    tick;

    // Single op: 5 + 7, check latency and busy window
    issue(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1, w);
    chk32("single_ready_now", w, 0);
    chk1("single_exec_busy", busy, 1'b1);
    chk32("single_exec_ctrl", 32'(alu_ctrl), 32'b0010);
    chk32("single_exec_a", alu_a, 32'd5);
    chk32("single_exec_b", alu_b, 32'd7);
    chk1("single_exec_rv0", resp_valid_0, 1'b0);
    tick;
    chk1("single_resp_rv0", resp_valid_0, 1'b1);
    chk1("single_resp_busy", busy, 1'b1);
    tick;
    chk1("single_idle_busy", busy, 1'b0);
    chk1("single_idle_rv0", resp_valid_0, 1'b0);
    chk32("single_sb_empty", sb.size(), 0);

    // Subtract equal on requester 1
    issue(1, 32'h0000_00FF, 32'h0000_00FF, 4'b0110, 32'd0, 1'b1, 1, w);
    chk1("sub_exec_owner", owner, 1'b1);
    tick;
    chk1("sub_rv1", resp_valid_1, 1'b1);
    chk1("sub_rv0", resp_valid_0, 1'b0);
    drain;

    // Tie fairness: both valid continuously; last grant was 1, so order is 0,1,0,1
    req_a_0 = 32'hF0; req_b_0 = 32'h3C; req_ctrl_0 = 4'b0000;
    req_a_1 = 32'hF0; req_b_1 = 32'h3C; req_ctrl_1 = 4'b0001;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      bit exp_id;
      int cnt;
      exp_id = k[0];
      cnt = 0;
      while (!(req_ready_0 || req_ready_1) && cnt < 20) begin
        tick;
        cnt++;
      end
      chk32("tie_ready_now", cnt, 0);
      chk1("tie_ready_win", rdy(exp_id), 1'b1);
      chk1("tie_ready_lose", rdy(!exp_id), 1'b0);
      sb.push_back('{id: exp_id, res: (exp_id ? 32'hFC : 32'h30), z: 1'b0});
      tick;
      chk1("tie_owner", owner, exp_id);
      drain;
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick;

    // Backpressure: hold resp_ready_0 low, requester 1 waits
    resp_ready_0 = 1'b0;
    issue(0, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 1, w);
    req_valid_1 = 1'b1; req_a_1 = 32'd1; req_b_1 = 32'd2; req_ctrl_1 = 4'b0010;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rv0", resp_valid_0, 1'b1);
      chk32("bp_result", resp_result, 32'd7);
      chk1("bp_zero", resp_zero, 1'b0);
      chk1("bp_owner", owner, 1'b0);
      chk1("bp_no_ready1", req_ready_1, 1'b0);
      tick;
    end
    resp_ready_0 = 1'b1;
    tick;
    chk32("bp_sb_empty", sb.size(), 0);
    chk1("bp_ready1_after_hs", req_ready_1, 1'b1);
    sb.push_back('{id: 1'b1, res: 32'd3, z: 1'b0});
    tick;
    req_valid_1 = 1'b0;
    drain;

    // Unsupported control code is passed through; ALU yields 0 and zero 0
    issue(0, 32'd1, 32'd1, 4'b0111, 32'd0, 1'b0, 1, w);
    chk32("unsup_ctrl", 32'(alu_ctrl), 32'b0111);
    tick;
    chk1("unsup_rv0", resp_valid_0, 1'b1);
    drain;

    // Reset during EXEC: op discarded, registers back to reset values
    issue(1, 32'd9, 32'd9, 4'b0010, 32'd0, 1'b0, 0, w);
    chk1("rexec_busy", busy, 1'b1);
    req_a_0 = 32'd5; req_b_0 = 32'd5; req_ctrl_0 = 4'b0010;
    req_a_1 = 32'd6; req_b_1 = 32'd6; req_ctrl_1 = 4'b0010;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    reset_n = 1'b0;
    #1;
    chk1("rexec_busy0", busy, 1'b0);
    chk1("rexec_rv1", resp_valid_1, 1'b0);
    chk32("rexec_alu_a", alu_a, 0);
    chk32("rexec_result", resp_result, 0);
    chk1("rexec_owner", owner, 1'b0);
    chk1("rexec_ready0_gated", req_ready_0, 1'b0);
    tick;
    reset_n = 1'b1;
    #1;
    chk1("rexec_tie_0", req_ready_0, 1'b1);
    chk1("rexec_tie_1", req_ready_1, 1'b0);
    sb.push_back('{id: 1'b0, res: 32'd10, z: 1'b0});
    tick;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    drain;

    // Quiet cycles: no stray responses
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("quiet_busy", busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer/arbiter that time-shares the single combinational ALU datapath between two requesters, for example the integer pipeline and a branch/address unit. Each requester issues an operation (A, B, 4-bit ALU control) over a valid/ready handshake. The block grants the ALU round-robin, registers the operands onto the ALU inputs, captures result and zero flag, and returns them to the owning requester over a valid/ready response handshake.

## Interface
- WIDTH, 32, operand/result width; must match the ALU width.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_0 / req_valid_1  in  1  requester i has an operation pending.
- req_ready_0 / req_ready_1  out  1  operation from requester i accepted this cycle.
- req_a_0 / req_a_1  in  WIDTH  operand A of requester i.
- req_b_0 / req_b_1  in  WIDTH  operand B of requester i.
- req_ctrl_0 / req_ctrl_1  in  4  ALU control code of requester i.
- resp_valid_0 / resp_valid_1  out  1  response for requester i is present.
- resp_ready_0 / resp_ready_1  in  1  requester i consumes the response.
- resp_result  out  WIDTH  captured ALU result; shared by both requesters, qualified by resp_valid_i.
- resp_zero  out  1  captured ALU zero flag.
- alu_a, alu_b  out  WIDTH  registered operands driven to the ALU.
- alu_ctrl  out  4  registered control driven to the ALU.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero  in  1  combinational ALU zero flag.
- busy  out  1  high in EXEC or RESP.
- owner  out  1  requester ID of the operation in flight; valid when busy.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Arbitrate among asserted req_valid_i.
  - A single valid requester wins.
  - If both are valid, the requester not equal to last_grant wins.
  - req_ready_i = (state==IDLE) & winner==i. This is combinational from req_valid_*, state and last_grant; only one ready is high at a time.
- **On accept:**
  - Register req_a/b/ctrl of the winner into alu_a/alu_b/alu_ctrl.
  - owner <= winner, last_grant <= winner, state -> EXEC.
- **EXEC (exactly 1 cycle):**
  - The ALU evaluates the registered operands.
  - At the clock edge, resp_result <= alu_result, resp_zero <= alu_zero, state -> RESP.
- **RESP:**
  - resp_valid_owner = 1. The other resp_valid is 0.
  - resp_result, resp_zero and owner are held stable until the handshake.
  - When resp_ready_owner is high, state -> IDLE.
  - resp_ready of the non-owner is ignored.
- **Pass-through behaviour:**
  - ALU control codes are passed unmodified, including unsupported ones. The ALU defines the result (unsupported codes give result 0, zero 0).
  - alu_a/alu_b/alu_ctrl hold their last values outside EXEC; they change only on accept.
- No new request is accepted while busy. req_valid held during busy must not be dropped or re-ordered; the requester keeps it asserted until its ready.

## Timing
- Reset values (async assertion, synchronous release at next edge):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - alu_a=0, alu_b=0, alu_ctrl=4'b0000.
  - resp_result=0, resp_zero=0, owner=0, busy=0.
  - resp_valid_*=0; req_ready_* gated low while reset_n=0.
- **Latency:** accept at edge N; EXEC during cycle N+1; resp_valid high from cycle N+2.
- **Throughput:** with resp_ready held high, one operation per 3 cycles. A new accept is possible in the cycle after the response handshake.
- **Simultaneous events:**
  - Both valid in IDLE: round-robin as above.
  - A requester deasserting valid in IDLE before ready: no accept, no state change.
- **Backpressure:** RESP is held indefinitely while resp_ready_owner=0; outputs stay bit-stable.
- **Reset mid-operation** (EXEC or RESP): the in-flight op is discarded, no response is issued, and all registers return to reset values.

## Test plan
- Single op: req_valid_0=1, a=5, b=7, ctrl=0010 → req_ready_0 that cycle; resp_valid_0 two cycles later, result=12, zero=0; busy high for 2 cycles; alu_ctrl=0010 during EXEC.
- Subtract equal: requester 1, a=b=32'h0000_00FF, ctrl=0110 → resp_valid_1, result=0, zero=1; resp_valid_0 stays 0.
- Tie fairness: both valid continuously, requester 0 ctrl=0000 a=F0 b=3C, requester 1 ctrl=0001 same operands → order 0,1,0,1; results 30, FC alternating; owner toggles.
- Backpressure: after a 3+4 add, hold resp_ready_0=0 for 5 cycles → resp_valid_0, result=7 and owner stable; req_ready_1 stays 0 despite req_valid_1=1; accept of requester 1 occurs the cycle after the handshake.
- Unsupported code: ctrl=0111, a=1, b=1 → result=0, zero=0, normal handshake timing.
- Reset in EXEC: pulse reset_n low for one cycle during EXEC → no resp_valid; all outputs at reset values; the next tie grants requester 0.
